decode_control_pipe: RTL and testbench
======================================

Name: decode_control_pipe

Overview:
- Parametrised, pipelined successor to the LEGv8 decode/control unit.
- Accepts 32-bit instructions from the instruction cache over a valid/ready handshake and decodes control flags, register IDs and a sign-extended immediate.
- Results pass through a registered output queue of depth FIFO_DEPTH to Operand Prep, ALU and Data Cache, with flush and illegal-opcode detection.

Parameters:
- DATA_WIDTH, 64, width of immediate output (≥32).
- REG_ID_WIDTH, 5, register ID width (≥5; upper bits zero-filled).
- FIFO_DEPTH, 2, output queue entries (power of 2, ≥2).

Ports:
- clock  in  1  main clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- flush  in  1  drops all queued entries; the input is not accepted that cycle.
- instruction  in  32  instruction word.
- instrValid  in  1  instruction present.
- instrReady  out  1  queue can accept.
- outValid  out  1  head entry valid.
- outReady  in  1  consumer takes head.
- unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag  out  1 each  control flags.
- aluControlCode  out  4  ALU operation.
- readRegister1, readRegister2, writeRegister  out  REG_ID_WIDTH  register IDs.
- immediate  out  DATA_WIDTH  extended immediate.
- illegal  out  1  opcode unrecognised.

Behaviour:
- Reset (resetN low, asynchronous):
  - Queue empty; outValid=0.
  - All head outputs 0.
  - instrReady=1 after release.
- Accept when instrValid && instrReady && !flush; decode is combinational into the tail entry.
- Latency: entry visible at the outputs the cycle after acceptance, with outValid=1.
- Pop when outValid && outReady.
- instrReady = !full || outReady. Simultaneous push and pop when full is legal; the count is unchanged.
- outValid = !empty. Head outputs are held stable while outValid && !outReady.
- When empty, outputs show the last popped entry (reset values if none); consumers qualify with outValid.
- Flush:
  - Pointers and count reset the next cycle; outValid=0.
  - Overrides simultaneous push and pop.
- Opcode decode, first match on instruction bits:
  - B (bits[31:26]=000101): unconditionalBranch=1, ALU 0111, imm=sext(bits[25:0]).
  - CBZ (bits[31:24]=10110100): branch=1, reg2Loc=1, ALU 0111, imm=sext(bits[23:5]).
  - ADDI (bits[31:22]=1001000100): aluSRC=1, regWriteFlag=1, ALU 0010, imm=zext(bits[21:10]).
  - SUBI (bits[31:22]=1101000100): as ADDI, but ALU 0110.
  - LDUR (bits[31:21]=11111000010): memRead=1, memToReg=1, aluSRC=1, regWriteFlag=1, ALU 0010, imm=sext(bits[20:12]).
  - STUR (bits[31:21]=11111000000): memWrite=1, aluSRC=1, reg2Loc=1, ALU 0010, imm=sext(bits[20:12]).
  - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000: regWriteFlag=1, ALU 0010 / 0110 / 0000 / 0001, imm=0.
  - Otherwise: illegal=1, all flags 0, ALU 0000, imm=0. The entry is still enqueued.
- Register fields:
  - readRegister1 = bits[9:5].
  - readRegister2 = reg2Loc ? bits[4:0] : bits[20:16].
  - writeRegister = bits[4:0].
  - All IDs are zero-extended to REG_ID_WIDTH.
- reg2Loc is internal only.
- Register IDs are passed through for B too; consumers ignore them.
- Sign extension replicates the field MSB up to DATA_WIDTH.
- Pointer wrap-around is modulo FIFO_DEPTH; the count range is 0..FIFO_DEPTH.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.

Test Plan:
- Decode sweep:
  - Push ADD X3,X1,X2 (0x8B020023) → next cycle: outValid=1, regWriteFlag=1, ALU=0010, rr1=1, rr2=2, wr=3, imm=0.
  - Push LDUR X5,[X2,#-8] (0xF85F8045) → memRead=memToReg=aluSRC=regWriteFlag=1, rr1=2, wr=5, imm=0xFFFF_FFFF_FFFF_FFF8.
  - Push STUR X5,[X2,#16] (0xF8010045) → memWrite=1, regWriteFlag=0, rr2=5, imm=16.
- Branches:
  - CBZ X7,#-1 (0xB4FFFFE7) → branch=1, rr2=7, imm=all ones.
  - B #4 (0x14000004) → unconditionalBranch=1, imm=4.
- Illegal: instruction 0x00000000 → illegal=1, all flags 0, entry dequeued normally.
- Backpressure:
  - Hold outReady=0 and push 3 → instrReady=0 after 2 accepts; third held.
  - Raise outReady → entries emerge in order, one per cycle.
  - Full with simultaneous push+pop → count stays 2.
- Flush: queue holding 2 entries, flush=1 with instrValid=1 → next cycle outValid=0; the flushed-cycle instruction is not enqueued.
- Reset: drop resetN mid-stream between clock edges → outValid and all outputs 0 immediately; after release, instrReady=1 and the next push decodes correctly.

Source files
------------

// File: rtl/decode_control_pipe.sv
// LEGv8 decode/control stage with a valid/ready input and a small registered output queue.
// Decoded entries are written at the tail; the head entry drives the outputs.
module decode_control_pipe #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned REG_ID_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    flush,
  input  logic [31:0]             instruction,
  input  logic                    instrValid,
  output logic                    instrReady,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    unconditionalBranch,
  output logic                    branch,
  output logic                    memRead,
  output logic                    memToReg,
  output logic                    memWrite,
  output logic                    aluSRC,
  output logic                    regWriteFlag,
  output logic [3:0]              aluControlCode,
  output logic [REG_ID_WIDTH-1:0] readRegister1,
  output logic [REG_ID_WIDTH-1:0] readRegister2,
  output logic [REG_ID_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0]   immediate,
  output logic                    illegal
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                    ubr;
    logic                    br;
    logic                    mrd;
    logic                    m2r;
    logic                    mwr;
    logic                    asrc;
    logic                    rwr;
    logic [3:0]              alu;
    logic [REG_ID_WIDTH-1:0] rr1;
    logic [REG_ID_WIDTH-1:0] rr2;
    logic [REG_ID_WIDTH-1:0] wr;
    logic [DATA_WIDTH-1:0]   imm;
    logic                    ill;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  entry_t             last_q, last_d;
  entry_t             dec;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               reg2loc;

  // Instruction decode: first matching opcode pattern wins.
  always_comb begin
    dec     = '0;
    reg2loc = 1'b0;
    if (instruction[31:26] == 6'b000101) begin
      dec.ubr = 1'b1;
      dec.alu = 4'b0111;
      dec.imm = DATA_WIDTH'($signed(instruction[25:0]));
    end else if (instruction[31:24] == 8'b10110100) begin
      dec.br  = 1'b1;
      reg2loc = 1'b1;
      dec.alu = 4'b0111;
      dec.imm = DATA_WIDTH'($signed(instruction[23:5]));
    end else if (instruction[31:22] == 10'b1001000100) begin
      dec.asrc = 1'b1;
      dec.rwr  = 1'b1;
      dec.alu  = 4'b0010;
      dec.imm  = DATA_WIDTH'(instruction[21:10]);
    end else if (instruction[31:22] == 10'b1101000100) begin
      dec.asrc = 1'b1;
      dec.rwr  = 1'b1;
      dec.alu  = 4'b0110;
      dec.imm  = DATA_WIDTH'(instruction[21:10]);
    end else if (instruction[31:21] == 11'b11111000010) begin
      dec.mrd  = 1'b1;
      dec.m2r  = 1'b1;
      dec.asrc = 1'b1;
      dec.rwr  = 1'b1;
      dec.alu  = 4'b0010;
      dec.imm  = DATA_WIDTH'($signed(instruction[20:12]));
    end else if (instruction[31:21] == 11'b11111000000) begin
      dec.mwr  = 1'b1;
      dec.asrc = 1'b1;
      reg2loc  = 1'b1;
      dec.alu  = 4'b0010;
      dec.imm  = DATA_WIDTH'($signed(instruction[20:12]));
    end else if (instruction[31:21] == 11'b10001011000) begin
      dec.rwr = 1'b1;
      dec.alu = 4'b0010;
    end else if (instruction[31:21] == 11'b11001011000) begin
      dec.rwr = 1'b1;
      dec.alu = 4'b0110;
    end else if (instruction[31:21] == 11'b10001010000) begin
      dec.rwr = 1'b1;
      dec.alu = 4'b0000;
    end else if (instruction[31:21] == 11'b10101010000) begin
      dec.rwr = 1'b1;
      dec.alu = 4'b0001;
    end else begin
      dec.ill = 1'b1;
    end
    dec.rr1 = REG_ID_WIDTH'(instruction[9:5]);
    dec.rr2 = reg2loc ? REG_ID_WIDTH'(instruction[4:0]) : REG_ID_WIDTH'(instruction[20:16]);
    dec.wr  = REG_ID_WIDTH'(instruction[4:0]);
  end

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign instrReady = !full || outReady;
  assign outValid   = !empty;
  assign push       = instrValid && instrReady && !flush;
  assign pop        = outValid && outReady && !flush;

  // Once drained, the outputs keep showing the most recently popped entry.
  assign head = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        last_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign unconditionalBranch = head.ubr;
  assign branch              = head.br;
  assign memRead             = head.mrd;
  assign memToReg            = head.m2r;
  assign memWrite            = head.mwr;
  assign aluSRC              = head.asrc;
  assign regWriteFlag        = head.rwr;
  assign aluControlCode      = head.alu;
  assign readRegister1       = head.rr1;
  assign readRegister2       = head.rr2;
  assign writeRegister       = head.wr;
  assign immediate           = head.imm;
  assign illegal             = head.ill;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Directed bench for decode_control_pipe: decode table, backpressure, flush and async reset.
module tb_decode_control_pipe;

  logic        clock = 1'b0;
  logic        resetN;
  logic        flush;
  logic [31:0] instruction;
  logic        instrValid;
  logic        instrReady;
  logic        outValid;
  logic        outReady;
  logic        unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag;
  logic [3:0]  aluControlCode;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [63:0] immediate;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  decode_control_pipe #(
    .DATA_WIDTH  (64),
    .REG_ID_WIDTH(5),
    .FIFO_DEPTH  (2)
  ) dut (
    .clock              (clock),
    .resetN             (resetN),
    .flush              (flush),
    .instruction        (instruction),
    .instrValid         (instrValid),
    .instrReady         (instrReady),
    .outValid           (outValid),
    .outReady           (outReady),
    .unconditionalBranch(unconditionalBranch),
    .branch             (branch),
    .memRead            (memRead),
    .memToReg           (memToReg),
    .memWrite           (memWrite),
    .aluSRC             (aluSRC),
    .regWriteFlag       (regWriteFlag),
    .aluControlCode     (aluControlCode),
    .readRegister1      (readRegister1),
    .readRegister2      (readRegister2),
    .writeRegister      (writeRegister),
    .immediate          (immediate),
    .illegal            (illegal)
  );

  always #5 clock = ~clock;

  // Flag order: {ubr, br, memRead, memToReg, memWrite, aluSRC, regWrite, illegal}
  function automatic logic [7:0] flags();
    return {unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag, illegal};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  fl;
    logic [3:0]  alu;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{32'h8B020023, 8'h02, 4'b0010, 5'd1,  5'd2,  5'd3,  64'd0};                  // ADD
    vecs[1]  = '{32'hF85F8045, 8'h36, 4'b0010, 5'd2,  5'd31, 5'd5,  64'hFFFF_FFFF_FFFF_FFF8}; // LDUR -8
    vecs[2]  = '{32'hF8010045, 8'h0C, 4'b0010, 5'd2,  5'd5,  5'd5,  64'd16};                 // STUR
    vecs[3]  = '{32'hB4FFFFE7, 8'h40, 4'b0111, 5'd31, 5'd7,  5'd7,  64'hFFFF_FFFF_FFFF_FFFF}; // CBZ -1
    vecs[4]  = '{32'h14000004, 8'h80, 4'b0111, 5'd0,  5'd0,  5'd4,  64'd4};                  // B +4
    vecs[5]  = '{32'h17FFFFFF, 8'h80, 4'b0111, 5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF}; // B -1
    vecs[6]  = '{32'h913FFC41, 8'h06, 4'b0010, 5'd2,  5'd31, 5'd1,  64'h0FFF};               // ADDI 0xFFF zext
    vecs[7]  = '{32'hD1000441, 8'h06, 4'b0110, 5'd2,  5'd0,  5'd1,  64'd1};                  // SUBI
    vecs[8]  = '{32'hCB020023, 8'h02, 4'b0110, 5'd1,  5'd2,  5'd3,  64'd0};                  // SUB
    vecs[9]  = '{32'h8A020023, 8'h02, 4'b0000, 5'd1,  5'd2,  5'd3,  64'd0};                  // AND
    vecs[10] = '{32'hAA020023, 8'h02, 4'b0001, 5'd1,  5'd2,  5'd3,  64'd0};                  // ORR
    vecs[11] = '{32'h00000000, 8'h01, 4'b0000, 5'd0,  5'd0,  5'd0,  64'd0};                  // illegal
  end

  initial begin
    resetN      = 1'b0;
    flush       = 1'b0;
    instruction = '0;
    instrValid  = 1'b0;
    outReady    = 1'b0;
    repeat (2) @(negedge clock);

    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_flags", 64'(flags()), 64'd0);
    check("rst_imm", immediate, 64'd0);
    resetN = 1'b1;
    @(negedge clock);
    check("rst_instrReady", 64'(instrReady), 64'd1);

    // Decode sweep: one entry at a time, consumer always ready
    outReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instruction = vecs[i].instr;
      instrValid  = 1'b1;
      cyc();
      instrValid = 1'b0;
      check($sformatf("dec%0d_valid", i), 64'(outValid), 64'd1);
      check($sformatf("dec%0d_flags", i), 64'(flags()), 64'(vecs[i].fl));
      check($sformatf("dec%0d_alu", i), 64'(aluControlCode), 64'(vecs[i].alu));
      check($sformatf("dec%0d_rr1", i), 64'(readRegister1), 64'(vecs[i].rr1));
      check($sformatf("dec%0d_rr2", i), 64'(readRegister2), 64'(vecs[i].rr2));
      check($sformatf("dec%0d_wr", i), 64'(writeRegister), 64'(vecs[i].wr));
      check($sformatf("dec%0d_imm", i), immediate, vecs[i].imm);
      cyc();
      check($sformatf("dec%0d_drained", i), 64'(outValid), 64'd0);
      check($sformatf("dec%0d_last_imm", i), immediate, vecs[i].imm);
    end

    // Backpressure: ADD, SUB accepted; ORR held
    outReady    = 1'b0;
    instruction = vecs[0].instr;
    instrValid  = 1'b1;
    cyc();
    check("bp_ready1", 64'(instrReady), 64'd1);
    instruction = vecs[8].instr;
    cyc();
    check("bp_ready_full", 64'(instrReady), 64'd0);
    check("bp_head_add", 64'(aluControlCode), 64'd2);
    instruction = vecs[10].instr;
    cyc();
    check("bp_still_full", 64'(instrReady), 64'd0);
    check("bp_head_stable", 64'(aluControlCode), 64'd2);
    check("bp_head_wr", 64'(writeRegister), 64'd3);
    outReady = 1'b1;
    #1 check("bp_ready_pop", 64'(instrReady), 64'd1);
    @(negedge clock);
    instrValid = 1'b0;
    outReady   = 1'b0;
    #1;
    check("bp_count_kept", 64'(instrReady), 64'd0);
    check("bp_head_sub", 64'(aluControlCode), 64'd6);
    outReady = 1'b1;
    cyc();
    check("bp_head_orr_v", 64'(outValid), 64'd1);
    check("bp_head_orr", 64'(aluControlCode), 64'd1);
    cyc();
    check("bp_empty", 64'(outValid), 64'd0);

    // Flush a full queue while a new instruction is offered
    outReady    = 1'b0;
    instruction = vecs[0].instr;
    instrValid  = 1'b1;
    cyc();
    instruction = vecs[1].instr;
    cyc();
    check("fl_full", 64'(instrReady), 64'd0);
    outReady    = 1'b1;
    flush       = 1'b1;
    instruction = vecs[2].instr;
    cyc();
    flush      = 1'b0;
    instrValid = 1'b0;
    check("fl_outValid", 64'(outValid), 64'd0);
    check("fl_ready", 64'(instrReady), 64'd1);
    cyc();
    check("fl_not_enq", 64'(outValid), 64'd0);

    // Asynchronous reset between clock edges
    outReady    = 1'b0;
    instruction = vecs[1].instr;
    instrValid  = 1'b1;
    cyc();
    instrValid = 1'b0;
    check("ar_pre_valid", 64'(outValid), 64'd1);
    check("ar_pre_imm", immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    #2 resetN = 1'b0;
    #1;
    check("ar_outValid", 64'(outValid), 64'd0);
    check("ar_imm", immediate, 64'd0);
    check("ar_flags", 64'(flags()), 64'd0);
    check("ar_wr", 64'(writeRegister), 64'd0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    check("ar_ready", 64'(instrReady), 64'd1);
    outReady    = 1'b1;
    instruction = vecs[3].instr;
    instrValid  = 1'b1;
    cyc();
    instrValid = 1'b0;
    check("ar_post_valid", 64'(outValid), 64'd1);
    check("ar_post_flags", 64'(flags()), 64'h40);
    check("ar_post_imm", immediate, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ar_post_rr2", 64'(readRegister2), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
